// File: rtl/fifo_stream_reader.sv
// Consumer end of the scratchpad FIFO: pops PAR_READ-lane words and serialises them
// into a one-element-per-beat valid/ready stream, one burst per start/length command.
module fifo_stream_reader #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned PAR_READ   = 4,
    parameter int unsigned LEN_WIDTH  = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear,
    input  logic                           start,
    input  logic [LEN_WIDTH-1:0]           length,
    input  logic                           fifo_empty,
    input  logic [PAR_READ*DATA_WIDTH-1:0] fifo_read_data,
    output logic                           fifo_read_en,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic                           out_last,
    output logic                           busy,
    output logic                           done
);

    localparam int unsigned LaneW = (PAR_READ > 1) ? $clog2(PAR_READ) : 1;
    localparam logic [LaneW-1:0] LastLane = LaneW'(PAR_READ - 1);

    typedef enum logic [1:0] {StIdle, StFetch, StSend} state_e;

    state_e                           state_q, state_d;
    logic [LEN_WIDTH-1:0]             remaining_q, remaining_d;
    logic [LaneW-1:0]                 lane_q, lane_d;
    logic [PAR_READ*DATA_WIDTH-1:0]   hold_q, hold_d;
    logic                             done_q, done_d;
    logic [DATA_WIDTH-1:0]            lane_words [PAR_READ];

    for (genvar i = 0; i < PAR_READ; i++) begin : g_lane
        assign lane_words[i] = hold_q[i*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        state_d      = state_q;
        remaining_d  = remaining_q;
        lane_d       = lane_q;
        hold_d       = hold_q;
        done_d       = 1'b0;
        fifo_read_en = 1'b0;
        out_valid    = 1'b0;
        out_last     = 1'b0;
        out_data     = '0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    if (length != '0) begin
                        remaining_d = length;
                        state_d     = StFetch;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            StFetch: begin
                fifo_read_en = !fifo_empty;
                if (!fifo_empty) begin
                    hold_d  = fifo_read_data;
                    lane_d  = '0;
                    state_d = StSend;
                end
            end
            StSend: begin
                out_valid = 1'b1;
                out_data  = lane_words[lane_q];
                out_last  = (remaining_q == LEN_WIDTH'(1));
                if (out_ready) begin
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    if (out_last) begin
                        // Unused lanes of the final word are simply dropped.
                        state_d = StIdle;
                        lane_d  = '0;
                        done_d  = 1'b1;
                    end else if (lane_q != LastLane) begin
                        lane_d = lane_q + LaneW'(1);
                    end else if (!fifo_empty) begin
                        // Reload in the same cycle so word boundaries cost no bubble.
                        fifo_read_en = 1'b1;
                        hold_d       = fifo_read_data;
                        lane_d       = '0;
                    end else begin
                        state_d = StFetch;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (clear) begin
            state_d      = StIdle;
            remaining_d  = '0;
            lane_d       = '0;
            done_d       = 1'b0;
            fifo_read_en = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            lane_q      <= '0;
            hold_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            lane_q      <= lane_d;
            hold_q      <= hold_d;
            done_q      <= done_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: a queue models the upstream FIFO, a monitor logs beats,
// pops and done; bursts come from a vector table plus hand-written abort sequences.
module tb_fifo_stream_reader;

    localparam int DW = 16;
    localparam int PR = 4;
    localparam int LW = 8;

    logic           clk = 1'b0;
    logic           rst, clear, start;
    logic [LW-1:0]  length;
    logic           fifo_empty;
    logic [PR*DW-1:0] fifo_read_data;
    logic           fifo_read_en, out_valid, out_ready, out_last, busy, done;
    logic [DW-1:0]  out_data;

    fifo_stream_reader #(.DATA_WIDTH(DW), .PAR_READ(PR), .LEN_WIDTH(LW)) dut (
        .clk            (clk),
        .rst            (rst),
        .clear          (clear),
        .start          (start),
        .length         (length),
        .fifo_empty     (fifo_empty),
        .fifo_read_data (fifo_read_data),
        .fifo_read_en   (fifo_read_en),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_last       (out_last),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        int mode;      // 0: out_ready always 1, 1: out_ready pattern 1,0,0,1
        int delay;     // cycles the FIFO stays empty after start
        int nwords;
        int exp_pops;
        int exp_left;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int pops = 0, underflow = 0, idle_pops = 0, done_cnt = 0, done_cyc = -1, cyc = 0;
    bit pop_now = 1'b0;
    logic [PR*DW-1:0] fq[$];
    logic [DW-1:0]    beat_data[$];
    logic             beat_last[$];
    int               beat_cyc[$];
    logic             stall_prev = 1'b0;
    logic [DW-1:0]    stall_data;
    logic             stall_last;
    bit               pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    vec_t             vecs [6];

    function automatic logic [DW-1:0] elem(input int k, input int j);
        return DW'((k + 1) * 32'h1000 + j * 32'h0011 + 5);
    endfunction

    function automatic logic [PR*DW-1:0] word(input int k);
        logic [PR*DW-1:0] w;
        for (int j = 0; j < PR; j++) w[j*DW +: DW] = elem(k, j);
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic refresh();
        fifo_empty     = (fq.size() == 0);
        fifo_read_data = (fq.size() == 0) ? '0 : fq[0];
    endtask

    task automatic push_words(input int base, input int n);
        for (int k = 0; k < n; k++) fq.push_back(word(base + k));
        refresh();
    endtask

    task automatic reset_log();
        beat_data.delete();
        beat_last.delete();
        beat_cyc.delete();
        pops = 0; underflow = 0; idle_pops = 0; done_cnt = 0; done_cyc = -1;
    endtask

    // Monitor: sample mid-cycle, apply FIFO pops just after the edge that performed them.
    always @(negedge clk) begin
        cyc++;
        pop_now = 1'b0;
        if (!rst) begin
            if (fifo_read_en && fifo_empty) underflow++;
            if (fifo_read_en && !busy) idle_pops++;
            pop_now = fifo_read_en && !fifo_empty;
            if (stall_prev && out_valid) begin
                check("stall_hold_data", 32'(out_data), 32'(stall_data));
                check("stall_hold_last", 32'(out_last), 32'(stall_last));
            end
            stall_prev = out_valid && !out_ready && !clear;
            stall_data = out_data;
            stall_last = out_last;
            if (out_valid && out_ready && !clear) begin
                beat_data.push_back(out_data);
                beat_last.push_back(out_last);
                beat_cyc.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    always @(posedge clk) begin
        #1;
        if (pop_now && fq.size() > 0) begin
            fq.delete(0);
            pops++;
        end
        pop_now = 1'b0;
        refresh();
    end

    task automatic run_burst(input string tag, input int len, input int mode, input int delay,
                             input int nwords, input int base, input int exp_pops,
                             input int exp_left);
        bit seen;
        reset_log();
        if (delay == 0) push_words(base, nwords);
        out_ready = 1'b1;
        start     = 1'b1;
        length    = LW'(len);
        @(posedge clk); #1;
        start = 1'b0;
        for (int d = 0; d < delay; d++) begin
            @(negedge clk);
            check({tag, "_wait_busy"}, 32'(busy), 32'd1);
            check({tag, "_wait_valid"}, 32'(out_valid), 32'd0);
            check({tag, "_wait_rden"}, 32'(fifo_read_en), 32'd0);
            @(posedge clk); #1;
        end
        if (delay != 0) push_words(base, nwords);
        seen = 1'b0;
        for (int c = 0; c < 200 && !seen; c++) begin
            out_ready = (mode == 0) ? 1'b1 : pat[c % 4];
            @(negedge clk);
            if (done) seen = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_beats"}, beat_data.size(), len);
        for (int i = 0; i < len && i < beat_data.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), 32'(beat_data[i]),
                  32'(elem(base + i / PR, i % PR)));
            check($sformatf("%s_last%0d", tag, i), 32'(beat_last[i]), 32'(i == len - 1));
        end
        if (beat_cyc.size() > 0)
            check({tag, "_done_lat"}, done_cyc - beat_cyc[beat_cyc.size()-1], 1);
        if (mode == 0 && beat_cyc.size() == len)
            check({tag, "_back2back"}, beat_cyc[len-1] - beat_cyc[0], len - 1);
        check({tag, "_pops"}, pops, exp_pops);
        check({tag, "_left"}, fq.size(), exp_left);
        check({tag, "_underflow"}, underflow, 0);
        check({tag, "_idle_pop"}, idle_pops, 0);
        out_ready = 1'b0;
        fq.delete();
        refresh();
    endtask

    // Abort a length-8 burst while its third element is presented, then resume.
    task automatic abort_burst(input string tag, input bit use_rst);
        reset_log();
        push_words(0, 3);
        out_ready = 1'b1;
        start     = 1'b1;
        length    = LW'(8);
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 50 && beat_data.size() < 2; c++) begin
            @(posedge clk); #1;
        end
        check({tag, "_reach_beat3"}, beat_data.size(), 2);
        if (use_rst) begin
            rst = 1'b1;
            #1;
            check({tag, "_busy"}, 32'(busy), 32'd0);
            check({tag, "_valid"}, 32'(out_valid), 32'd0);
            check({tag, "_rden"}, 32'(fifo_read_en), 32'd0);
            @(posedge clk); #1;
            rst = 1'b0;
        end else begin
            clear = 1'b1;
            @(negedge clk);
            check({tag, "_rden"}, 32'(fifo_read_en), 32'd0);
            @(posedge clk); #1;
            clear = 1'b0;
            check({tag, "_busy"}, 32'(busy), 32'd0);
            check({tag, "_valid"}, 32'(out_valid), 32'd0);
        end
        @(negedge clk);
        check({tag, "_no_done"}, 32'(done), 32'd0);
        check({tag, "_done_cnt"}, done_cnt, 0);
        check({tag, "_beats"}, beat_data.size(), 2);
        check({tag, "_pops"}, pops, 1);
        check({tag, "_left"}, fq.size(), 2);
        @(posedge clk); #1;
        run_burst({tag, "_resume"}, 4, 0, 0, 0, 1, 1, 1);
    endtask

    initial begin
        vecs[0] = '{len: 8, mode: 0, delay: 0, nwords: 2, exp_pops: 2, exp_left: 0};
        vecs[1] = '{len: 6, mode: 0, delay: 0, nwords: 2, exp_pops: 2, exp_left: 0};
        vecs[2] = '{len: 8, mode: 1, delay: 0, nwords: 2, exp_pops: 2, exp_left: 0};
        vecs[3] = '{len: 4, mode: 0, delay: 5, nwords: 1, exp_pops: 1, exp_left: 0};
        vecs[4] = '{len: 5, mode: 1, delay: 0, nwords: 3, exp_pops: 2, exp_left: 1};
        vecs[5] = '{len: 1, mode: 0, delay: 0, nwords: 1, exp_pops: 1, exp_left: 0};

        rst = 1'b1; clear = 1'b0; start = 1'b0; length = '0; out_ready = 1'b0;
        refresh();
        push_words(0, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rden", 32'(fifo_read_en), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("idle_rden", 32'(fifo_read_en), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        fq.delete();
        refresh();

        for (int i = 0; i < 6; i++)
            run_burst($sformatf("vec%0d", i), vecs[i].len, vecs[i].mode, vecs[i].delay,
                      vecs[i].nwords, 0, vecs[i].exp_pops, vecs[i].exp_left);

        // Zero-length command: done next cycle, never busy, no pop.
        reset_log();
        push_words(0, 1);
        start  = 1'b1;
        length = '0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("len0_done", 32'(done), 32'd1);
        check("len0_busy", 32'(busy), 32'd0);
        check("len0_rden", 32'(fifo_read_en), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("len0_done_pulse", 32'(done), 32'd0);
        check("len0_pops", pops, 0);
        @(posedge clk); #1;
        fq.delete();
        refresh();

        abort_burst("clear", 1'b0);
        abort_burst("rst", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
